multi_channel_wave_gen: RTL and testbench

MULTI_CHANNEL_WAVE_GEN -- requirements
Module: multi_channel_wave_gen

---
 rtl/multi_channel_wave_gen.sv | 244 ++++++++++++++++++++++++
 tb/tb_multi_channel_wave_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_wave_gen.sv
// Multi-channel phase-accumulator waveform generator with byte-serial host register writes.
// Optional register readback on rd_data is enabled by defining MULTI_CHANNEL_WAVE_GEN_READBACK_EN.
module multi_channel_wave_gen #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned PHASE_BITS   = 16,
    parameter int unsigned STEP_BITS    = 13
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [7:0]                          data_in,
    input  logic [$clog2(NUM_CHANNELS)+1:0]     addr,
    input  logic                                data_part,
    input  logic                                sample_req,
    output logic [PHASE_BITS-1:0]               sample_out,
    output logic                                sample_valid,
    output logic                                busy,
    output logic [15:0]                         rd_data
);

    localparam int unsigned ADDR_W = $clog2(NUM_CHANNELS) + 2;
    localparam int unsigned CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned ACC_W  = PHASE_BITS + $clog2(NUM_CHANNELS);
    localparam int unsigned CTRL_W = 6;

    localparam logic [1:0] MODE_TRI = 2'd1;
    localparam logic [1:0] MODE_SAW = 2'd2;
    localparam logic [1:0] MODE_SQR = 2'd3;

    localparam logic [1:0] REG_PHASE = 2'd0;
    localparam logic [1:0] REG_STEP  = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;

    localparam logic [PHASE_BITS-1:0] PHASE_RESET = PHASE_BITS'(1) << (PHASE_BITS - 3);
    localparam logic [PHASE_BITS-1:0] PHASE_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Per-channel register file; dir: 0 = counting up, 1 = counting down
    logic [PHASE_BITS-1:0] phase [NUM_CHANNELS];
    logic [STEP_BITS-1:0]  step  [NUM_CHANNELS];
    logic [CTRL_W-1:0]     ctrl  [NUM_CHANNELS];
    logic                  dir   [NUM_CHANNELS];

    seq_state_t        state;
    logic [CH_W-1:0]   k;
    logic [ACC_W-1:0]  acc;

    logic              sync1, sync2, sync3;
    logic [7:0]        low_byte;
    logic              wr_rise, wr_fall;
    logic [15:0]       wdata;
    logic [ADDR_W-1:0] addr_ch;
    logic [1:0]        reg_sel;

    logic [PHASE_BITS-1:0] cur_phase;
    logic [STEP_BITS-1:0]  cur_step;
    logic [CTRL_W-1:0]     cur_ctrl;
    logic                  cur_dir;
    logic [PHASE_BITS-1:0] step_ext;
    logic [PHASE_BITS-1:0] sum_up;
    logic [PHASE_BITS-1:0] sum_dn;
    logic [PHASE_BITS-1:0] new_phase;
    logic                  new_dir;
    logic [PHASE_BITS-1:0] contrib;
    logic [ACC_W-1:0]      acc_sum;

    assign wr_rise = sync2 & ~sync3;
    assign wr_fall = ~sync2 & sync3;
    assign wdata   = {data_in, low_byte};
    assign addr_ch = addr >> 2;
    assign reg_sel = addr[1:0];

    // Host strobe synchronizer, edge-detect history and low-byte capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync3    <= 1'b1;
            low_byte <= 8'h00;
        end else begin
            sync1 <= data_part;
            sync2 <= sync1;
            sync3 <= sync2;
            if (wr_fall) begin
                low_byte <= data_in;
            end
        end
    end

    // Select the channel under service and compute its update and contribution
    always_comb begin
        cur_phase = '0;
        cur_step  = '0;
        cur_ctrl  = '0;
        cur_dir   = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (k == CH_W'(i)) begin
                cur_phase = phase[i];
                cur_step  = step[i];
                cur_ctrl  = ctrl[i];
                cur_dir   = dir[i];
            end
        end

        step_ext  = PHASE_BITS'(cur_step);
        sum_up    = cur_phase + step_ext;
        sum_dn    = cur_phase - step_ext;
        new_phase = cur_phase;
        new_dir   = cur_dir;
        contrib   = '0;

        case (cur_ctrl[1:0])
            MODE_TRI: begin
                contrib = cur_phase >> cur_ctrl[5:2];
                if (!cur_dir) begin
                    if (sum_up[PHASE_BITS-1 -: 2] == 2'b11) begin
                        new_dir = 1'b1;
                    end else begin
                        new_phase = sum_up;
                    end
                end else begin
                    if (sum_dn[PHASE_BITS-1 -: 2] == 2'b00) begin
                        new_dir = 1'b0;
                    end else begin
                        new_phase = sum_dn;
                    end
                end
            end
            MODE_SAW: begin
                contrib   = cur_phase >> cur_ctrl[5:2];
                new_phase = sum_up;
            end
            MODE_SQR: begin
                contrib   = {PHASE_BITS{cur_phase[PHASE_BITS-1]}} >> cur_ctrl[5:2];
                new_phase = sum_up;
            end
            default: begin
            end
        endcase

        acc_sum = acc + ACC_W'(contrib);
    end

    // Channel registers; the host write is placed last so it overrides a same-cycle sequencer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                phase[i] <= PHASE_RESET;
                step[i]  <= '0;
                ctrl[i]  <= '0;
                dir[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (state == RUN && k == CH_W'(i)) begin
                    phase[i] <= new_phase;
                    dir[i]   <= new_dir;
                end
                if (wr_rise && addr_ch == ADDR_W'(i)) begin
                    case (reg_sel)
                        REG_PHASE: phase[i] <= PHASE_BITS'(wdata);
                        REG_STEP:  step[i]  <= STEP_BITS'(wdata);
                        REG_CTRL: begin
                            ctrl[i] <= CTRL_W'(wdata);
                            dir[i]  <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Sample sequencer: one channel per RUN cycle, result published on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= '0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_req) begin
                        state <= RUN;
                        k     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (k == CH_W'(NUM_CHANNELS - 1)) begin
                        state        <= DONE;
                        sample_valid <= 1'b1;
                        if (acc_sum > ACC_W'(PHASE_MAX)) begin
                            sample_out <= PHASE_MAX;
                        end else begin
                            sample_out <= PHASE_BITS'(acc_sum);
                        end
                    end else begin
                        k <= k + CH_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MULTI_CHANNEL_WAVE_GEN_READBACK_EN
    // Combinational register readback; reserved and unmapped addresses read 0
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (addr_ch == ADDR_W'(i)) begin
                case (reg_sel)
                    REG_PHASE: rd_data = 16'(phase[i]);
                    REG_STEP:  rd_data = 16'(step[i]);
                    REG_CTRL:  rd_data = 16'(ctrl[i]);
                    default:   rd_data = '0;
                endcase
            end
        end
    end
`else
    assign rd_data = '0;
`endif

endmodule

// File: tb/tb_multi_channel_wave_gen.sv
// Self-checking bench for multi_channel_wave_gen: directed scenarios plus randomized
// register programming, checked against a per-channel arithmetic reference model.
module tb_multi_channel_wave_gen;

    localparam int NC = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_in;
    logic [3:0]  addr;
    logic        data_part;
    logic        sample_req;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic [15:0] rd_data;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_phase [NC];
    int m_step  [NC];
    int m_mode  [NC];
    int m_shift [NC];
    int m_down  [NC];

    multi_channel_wave_gen #(
        .NUM_CHANNELS(NC),
        .PHASE_BITS  (16),
        .STEP_BITS   (13)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .addr        (addr),
        .data_part   (data_part),
        .sample_req  (sample_req),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            m_phase[i] = 'h2000;
            m_step[i]  = 0;
            m_mode[i]  = 0;
            m_shift[i] = 0;
            m_down[i]  = 0;
        end
    endfunction

    function automatic int model_rd(input int ch, input int r);
        case (r)
            0:       return m_phase[ch];
            1:       return m_step[ch];
            2:       return m_shift[ch] * 4 + m_mode[ch];
            default: return 0;
        endcase
    endfunction

    // One mixed sample: sum of attenuated pre-update values, clipped at 0xFFFF; then advance channels
    function automatic int model_sample();
        int total_s = 0;
        for (int i = 0; i < NC; i++) begin
            int nxt;
            case (m_mode[i])
                1: begin
                    total_s += m_phase[i] / (1 << m_shift[i]);
                    nxt = m_down[i] ? (m_phase[i] - m_step[i] + 65536) % 65536
                                    : (m_phase[i] + m_step[i]) % 65536;
                    if ((m_down[i] == 0 && nxt >= 'hC000) || (m_down[i] == 1 && nxt < 'h4000))
                        m_down[i] = 1 - m_down[i];
                    else
                        m_phase[i] = nxt;
                end
                2, 3: begin
                    if (m_mode[i] == 2)
                        total_s += m_phase[i] / (1 << m_shift[i]);
                    else if (m_phase[i] >= 'h8000)
                        total_s += 65535 / (1 << m_shift[i]);
                    m_phase[i] = (m_phase[i] + m_step[i]) % 65536;
                end
                default: begin
                end
            endcase
        end
        return (total_s > 65535) ? 65535 : total_s;
    endfunction

    // Byte-serial host write: low byte on strobe fall, high byte and commit on strobe rise
    task automatic write_reg(input int ch, input int r, input int val);
        @(negedge clk);
        addr      = 4'(ch * 4 + r);
        data_in   = 8'(val);
        data_part = 1'b0;
        repeat (4) @(negedge clk);
        data_in   = 8'(val >> 8);
        data_part = 1'b1;
        repeat (4) @(negedge clk);
        case (r)
            0: m_phase[ch] = val & 'hFFFF;
            1: m_step[ch]  = val & 'h1FFF;
            2: begin
                m_mode[ch]  = val & 3;
                m_shift[ch] = (val >> 2) & 'hF;
                m_down[ch]  = 0;
            end
            default: begin
            end
        endcase
`ifdef MULTI_CHANNEL_WAVE_GEN_READBACK_EN
        chk("readback", 32'(rd_data), 32'(model_rd(ch, r)));
`else
        chk("rd_tied", 32'(rd_data), 32'h0);
`endif
    endtask

    // Single request; checks busy/valid every cycle of the transaction and the result
    task automatic do_req(input string tag);
        int exp;
        exp = model_sample();
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        for (int c = 1; c <= NC + 1; c++) begin
            chk({tag, "_busy"}, 32'(busy), 32'h1);
            chk({tag, "_valid"}, 32'(sample_valid), 32'(c == NC + 1));
            if (c == NC + 1) chk({tag, "_sample"}, 32'(sample_out), 32'(exp));
            @(negedge clk);
        end
        chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
        chk({tag, "_idle_valid"}, 32'(sample_valid), 32'h0);
    endtask

    initial begin
        int exp1, exp2, nvalid;
        rst_n      = 1'b0;
        data_in    = 8'h00;
        addr       = 4'h0;
        data_part  = 1'b1;
        sample_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_sample_out", 32'(sample_out), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
`ifdef MULTI_CHANNEL_WAVE_GEN_READBACK_EN
        chk("rst_rd_phase", 32'(rd_data), 32'h2000);
`endif
        rst_n = 1'b1;

        // STEP write through the synchronizer; all channels still off
        write_reg(0, 1, 'h0100);
        do_req("all_off");

        // Sawtooth wrap
        write_reg(0, 0, 'hF800);
        write_reg(0, 1, 'h1000);
        write_reg(0, 2, 'h0002);
        do_req("saw_first");
        do_req("saw_wrap");

        // Triangle turnaround at the top quadrant
        write_reg(0, 0, 'hB800);
        write_reg(0, 2, 'h0001);
        do_req("tri_turn");
        do_req("tri_hold");
        do_req("tri_down");

        // Four square channels high -> clipped sum
        for (int i = 0; i < NC; i++) begin
            write_reg(i, 0, 'h8000);
            write_reg(i, 2, 'h0003);
        end
        do_req("square_sat");

        // Held request: samples at t+5 and t+11 only
        exp1 = model_sample();
        exp2 = model_sample();
        nvalid = 0;
        @(negedge clk);
        sample_req = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (sample_valid) nvalid++;
            chk("hold_valid", 32'(sample_valid), 32'(c == 5 || c == 11));
            chk("hold_busy", 32'(busy), 32'((c >= 1 && c <= 5) || (c >= 7 && c <= 11)));
            if (c == 5) chk("hold_sample1", 32'(sample_out), 32'(exp1));
            if (c == 11) chk("hold_sample2", 32'(sample_out), 32'(exp2));
            if (c == 10) sample_req = 1'b0;
        end
        chk("hold_count", 32'(nvalid), 32'h2);

        // Randomized programming and requests
        for (int it = 0; it < 24; it++) begin
            int ch, r, val, mode;
            ch = int'($urandom_range(0, NC - 1));
            r  = int'($urandom_range(0, 3));
            if (r == 2) begin
                mode = int'($urandom_range(0, 3));
                val  = int'($urandom & 'hFFC0) | mode;
                if (mode != 3) val |= int'($urandom_range(0, 15)) << 2;
            end else begin
                val = int'($urandom & 'hFFFF);
            end
            write_reg(ch, r, val);
            do_req("random");
        end

        // Reset in the middle of a RUN
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(sample_valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_sample_out", 32'(sample_out), 32'h0);
        nvalid = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sample_valid) nvalid++;
        end
        chk("midrst_no_pulse", 32'(nvalid), 32'h0);
        rst_n = 1'b1;
        model_reset();
        write_reg(0, 2, 'h0002);
        do_req("post_rst_phase");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
